// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, ALUOp encodings, the ID/EX control bundle
// and the main-control decode function.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Bit order matches id_ex_ctrl[9:0], MSB first.
  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
    logic       valid;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    ctrl_t c;
    c = CTRL_BUBBLE;
    case (op)
      OP_RTYPE: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALUOP_FUNCT;
        c.valid     = 1'b1;
      end
      OP_LW: begin
        c.alu_src    = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.mem_read   = 1'b1;
        c.alu_op     = ALUOP_ADD;
        c.valid      = 1'b1;
      end
      OP_SW: begin
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
        c.alu_op    = ALUOP_ADD;
        c.valid     = 1'b1;
      end
      OP_BEQ: begin
        c.branch = 1'b1;
        c.alu_op = ALUOP_SUB;
        c.valid  = 1'b1;
      end
      OP_ADDI: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALUOP_ADD;
        c.valid     = 1'b1;
      end
      default: c = CTRL_BUBBLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/regfile.sv
// 2-read/1-write register file with $0 hard-wired to zero, write-through bypass
// and asynchronous clear.
module regfile #(
  parameter int NREG = 32,
  parameter int W    = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [W-1:0]  rdata1,
  output logic [W-1:0]  rdata2
);

  logic [W-1:0] mem_q [NREG];
  logic [W-1:0] mem_d [NREG];

  always_comb begin
    mem_d = mem_q;
    if (we && waddr != '0) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_q <= '{default: '0};
    else     mem_q <= mem_d;
  end

  // A write landing this edge is forwarded so decode sees the new value now.
  always_comb begin
    if (raddr1 == '0)                  rdata1 = '0;
    else if (we && waddr == raddr1)    rdata1 = wdata;
    else                               rdata1 = mem_q[raddr1];
    if (raddr2 == '0)                  rdata2 = '0;
    else if (we && waddr == raddr2)    rdata2 = wdata;
    else                               rdata2 = mem_q[raddr2];
  end

endmodule

// File: rtl/decode_stage.sv
// MIPS ID stage: IF/ID register, register-file read, main control decode,
// load-use stall detection and branch flush feeding the ID/EX register.
module decode_stage
  import mips_pkg::*;
#(
  parameter int NREG = 32,
  parameter int W    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [W-1:0]             nPC,
  input  logic [W-1:0]             IR,
  input  logic                     PCSrc,
  input  logic                     wb_we,
  input  logic [$clog2(NREG)-1:0]  wb_addr,
  input  logic [W-1:0]             wb_data,
  input  logic                     ex_mem_read,
  input  logic [$clog2(NREG)-1:0]  ex_rt,
  output logic                     stall,
  output logic [W-1:0]             id_ex_npc,
  output logic [W-1:0]             id_ex_rd1,
  output logic [W-1:0]             id_ex_rd2,
  output logic [W-1:0]             id_ex_imm,
  output logic [$clog2(NREG)-1:0]  id_ex_rt,
  output logic [$clog2(NREG)-1:0]  id_ex_rd,
  output logic [$clog2(NREG)-1:0]  id_ex_rs,
  output logic [9:0]               id_ex_ctrl
);

  localparam int AW = $clog2(NREG);

  logic [W-1:0]  ifid_npc_q, ifid_npc_d;
  logic [W-1:0]  ifid_ir_q, ifid_ir_d;

  logic [W-1:0]  id_ex_npc_q, id_ex_npc_d;
  logic [W-1:0]  id_ex_rd1_q, id_ex_rd1_d;
  logic [W-1:0]  id_ex_rd2_q, id_ex_rd2_d;
  logic [W-1:0]  id_ex_imm_q, id_ex_imm_d;
  logic [AW-1:0] id_ex_rt_q, id_ex_rt_d;
  logic [AW-1:0] id_ex_rd_q, id_ex_rd_d;
  logic [AW-1:0] id_ex_rs_q, id_ex_rs_d;
  ctrl_t         id_ex_ctrl_q, id_ex_ctrl_d;

  logic [5:0]    op;
  logic [AW-1:0] rs, rt, rd;
  logic [W-1:0]  rf_rd1, rf_rd2;
  logic [W-1:0]  imm_ext;
  ctrl_t         ctrl_dec;

  assign op      = ifid_ir_q[31:26];
  assign rs      = ifid_ir_q[25:21];
  assign rt      = ifid_ir_q[20:16];
  assign rd      = ifid_ir_q[15:11];
  assign imm_ext = {{(W-16){ifid_ir_q[15]}}, ifid_ir_q[15:0]};
  assign ctrl_dec = decode_ctrl(op);

  regfile #(.NREG(NREG), .W(W)) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_we),
    .waddr  (wb_addr),
    .wdata  (wb_data),
    .raddr1 (rs),
    .raddr2 (rt),
    .rdata1 (rf_rd1),
    .rdata2 (rf_rd2)
  );

  // A flush makes the stalled instruction irrelevant, so it never holds fetch.
  assign stall = ex_mem_read && (ex_rt != '0) && ((ex_rt == rs) || (ex_rt == rt)) && !PCSrc;

  always_comb begin
    ifid_npc_d = ifid_npc_q;
    ifid_ir_d  = ifid_ir_q;
    if (PCSrc) begin
      ifid_npc_d = '0;
      ifid_ir_d  = NOP_INSTR;
    end else if (!stall) begin
      ifid_npc_d = nPC;
      ifid_ir_d  = IR;
    end
  end

  always_comb begin
    id_ex_npc_d  = '0;
    id_ex_rd1_d  = '0;
    id_ex_rd2_d  = '0;
    id_ex_imm_d  = '0;
    id_ex_rt_d   = '0;
    id_ex_rd_d   = '0;
    id_ex_rs_d   = '0;
    id_ex_ctrl_d = CTRL_BUBBLE;
    if (!stall && !PCSrc) begin
      id_ex_npc_d  = ifid_npc_q;
      id_ex_rd1_d  = rf_rd1;
      id_ex_rd2_d  = rf_rd2;
      id_ex_imm_d  = imm_ext;
      id_ex_rt_d   = rt;
      id_ex_rd_d   = rd;
      id_ex_rs_d   = rs;
      id_ex_ctrl_d = ctrl_dec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_npc_q   <= '0;
      ifid_ir_q    <= NOP_INSTR;
      id_ex_npc_q  <= '0;
      id_ex_rd1_q  <= '0;
      id_ex_rd2_q  <= '0;
      id_ex_imm_q  <= '0;
      id_ex_rt_q   <= '0;
      id_ex_rd_q   <= '0;
      id_ex_rs_q   <= '0;
      id_ex_ctrl_q <= CTRL_BUBBLE;
    end else begin
      ifid_npc_q   <= ifid_npc_d;
      ifid_ir_q    <= ifid_ir_d;
      id_ex_npc_q  <= id_ex_npc_d;
      id_ex_rd1_q  <= id_ex_rd1_d;
      id_ex_rd2_q  <= id_ex_rd2_d;
      id_ex_imm_q  <= id_ex_imm_d;
      id_ex_rt_q   <= id_ex_rt_d;
      id_ex_rd_q   <= id_ex_rd_d;
      id_ex_rs_q   <= id_ex_rs_d;
      id_ex_ctrl_q <= id_ex_ctrl_d;
    end
  end

  assign id_ex_npc  = id_ex_npc_q;
  assign id_ex_rd1  = id_ex_rd1_q;
  assign id_ex_rd2  = id_ex_rd2_q;
  assign id_ex_imm  = id_ex_imm_q;
  assign id_ex_rt   = id_ex_rt_q;
  assign id_ex_rd   = id_ex_rd_q;
  assign id_ex_rs   = id_ex_rs_q;
  assign id_ex_ctrl = id_ex_ctrl_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: stimulus queues expected values tagged with the
// cycle they must appear in; a negedge monitor pops and compares them.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] nPC, IR, wb_data;
  logic        PCSrc, wb_we, ex_mem_read;
  logic [4:0]  wb_addr, ex_rt;
  logic        stall;
  logic [31:0] id_ex_npc, id_ex_rd1, id_ex_rd2, id_ex_imm;
  logic [4:0]  id_ex_rt, id_ex_rd, id_ex_rs;
  logic [9:0]  id_ex_ctrl;

  decode_stage #(.NREG(32), .W(32)) dut (
    .clk(clk), .rst(rst), .nPC(nPC), .IR(IR), .PCSrc(PCSrc),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .stall(stall),
    .id_ex_npc(id_ex_npc), .id_ex_rd1(id_ex_rd1), .id_ex_rd2(id_ex_rd2),
    .id_ex_imm(id_ex_imm), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
    .id_ex_rs(id_ex_rs), .id_ex_ctrl(id_ex_ctrl)
  );

  always #5 clk = ~clk;

  localparam int K_CTRL = 0, K_IMM = 1, K_RD1 = 2, K_RD2 = 3, K_STALL = 4,
                 K_NPC = 5, K_IFID = 6, K_RT = 7, K_RD = 8, K_RS = 9;

  // Hand-derived control words {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUOp,Valid}
  localparam logic [31:0] C_R    = 32'h245;
  localparam logic [31:0] C_LW   = 32'h1E1;
  localparam logic [31:0] C_SW   = 32'h111;
  localparam logic [31:0] C_BEQ  = 32'h00B;
  localparam logic [31:0] C_NONE = 32'h000;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t keep[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [31:0] sample(input int kind);
    case (kind)
      K_CTRL:  return {22'd0, id_ex_ctrl};
      K_IMM:   return id_ex_imm;
      K_RD1:   return id_ex_rd1;
      K_RD2:   return id_ex_rd2;
      K_STALL: return {31'd0, stall};
      K_NPC:   return id_ex_npc;
      K_IFID:  return dut.ifid_ir_q;
      K_RT:    return {27'd0, id_ex_rt};
      K_RD:    return {27'd0, id_ex_rd};
      default: return {27'd0, id_ex_rs};
    endcase
  endfunction

  always @(negedge clk) begin
    keep = {};
    foreach (sb[i]) begin
      if (sb[i].cyc == cyc) begin
        logic [31:0] act;
        act = sample(sb[i].kind);
        checks = checks + 1;
        if (act !== sb[i].val) begin
          errors = errors + 1;
          $display("FAIL %s @cycle %0d: got 0x%08h expected 0x%08h", sb[i].name, cyc, act, sb[i].val);
        end
      end else if (sb[i].cyc < cyc) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL %s stale: due cycle %0d, now %0d, expected 0x%08h", sb[i].name, sb[i].cyc, cyc, sb[i].val);
      end else begin
        keep.push_back(sb[i]);
      end
    end
    sb = keep;
  end

  function automatic void push(input int c, input int k, input logic [31:0] v, input string n);
    exp_t e;
    e.cyc = c; e.kind = k; e.val = v; e.name = n;
    sb.push_back(e);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; nPC = '0; IR = '0; PCSrc = 1'b0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0; ex_mem_read = 1'b0; ex_rt = '0;
    step(); step();
    rst = 1'b0;
    push(cyc, K_CTRL, C_NONE, "reset_ctrl");
    push(cyc, K_NPC, 32'h0, "reset_npc");
    push(cyc, K_RD1, 32'h0, "reset_rd1");
    push(cyc, K_IFID, 32'h0, "reset_ifid");
    push(cyc, K_STALL, 32'h0, "reset_stall");

    // $1 = 0x10 written the same edge lw enters IF/ID
    wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'h10;
    IR = 32'h8C220004; nPC = 32'h104;
    push(cyc + 2, K_CTRL, C_LW, "lw_ctrl");
    push(cyc + 2, K_IMM, 32'h4, "lw_imm");
    push(cyc + 2, K_RD1, 32'h10, "lw_rd1");
    push(cyc + 2, K_NPC, 32'h104, "lw_npc");
    push(cyc + 2, K_RT, 32'd2, "lw_rt");
    push(cyc + 2, K_RS, 32'd1, "lw_rs");
    step();
    wb_we = 1'b0; IR = 32'h00602020; nPC = 32'h108;   // add $4,$3,$0
    step();
    wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEADBEEF;
    IR = 32'h00412820; nPC = 32'h10C;                 // add $5,$2,$1
    push(cyc + 1, K_CTRL, C_R, "add4_ctrl");
    push(cyc + 1, K_RD1, 32'hDEADBEEF, "bypass_rd1");
    push(cyc + 1, K_RD2, 32'h0, "add4_rd2_zero");
    push(cyc + 1, K_RD, 32'd4, "add4_rd");
    push(cyc + 1, K_NPC, 32'h108, "add4_npc");
    step();

    // load-use stall on $2
    wb_we = 1'b0; ex_mem_read = 1'b1; ex_rt = 5'd2;
    IR = 32'h20A60007; nPC = 32'h110;                 // addi $6,$5,7
    push(cyc, K_STALL, 32'h1, "loaduse_stall");
    push(cyc + 1, K_IFID, 32'h00412820, "stall_ifid_hold");
    push(cyc + 1, K_CTRL, C_NONE, "stall_bubble_ctrl");
    push(cyc + 1, K_NPC, 32'h0, "stall_bubble_npc");
    step();
    ex_mem_read = 1'b0;
    push(cyc, K_STALL, 32'h0, "stall_drops");
    push(cyc + 1, K_CTRL, C_R, "add5_ctrl");
    push(cyc + 1, K_RD, 32'd5, "add5_rd");
    push(cyc + 1, K_RD2, 32'h10, "add5_rd2");
    push(cyc + 1, K_IFID, 32'h20A60007, "addi_in_ifid");
    step();

    // stall on addi's rs, then flush during the stall
    ex_mem_read = 1'b1; ex_rt = 5'd5; IR = 32'hFC000000;
    push(cyc, K_STALL, 32'h1, "stall_before_flush");
    push(cyc + 1, K_IFID, 32'h20A60007, "ifid_hold2");
    step();
    PCSrc = 1'b1;
    push(cyc, K_STALL, 32'h0, "flush_kills_stall");
    push(cyc + 1, K_IFID, 32'h0, "flush_ifid_nop");
    push(cyc + 1, K_CTRL, C_NONE, "flush_ctrl");
    step();

    // $0 write discarded and not bypassed; beq with negative imm
    PCSrc = 1'b0; ex_mem_read = 1'b0;
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234;
    IR = 32'h1000FFFF; nPC = 32'h200;                 // beq $0,$0,-1
    step();
    IR = 32'hAC270008; nPC = 32'h204;                 // sw $7,8($1)
    push(cyc + 1, K_CTRL, C_BEQ, "beq_ctrl");
    push(cyc + 1, K_IMM, 32'hFFFFFFFF, "beq_imm_sext");
    push(cyc + 1, K_RD1, 32'h0, "r0_read");
    push(cyc + 1, K_NPC, 32'h200, "beq_npc");
    step();
    wb_addr = 5'd7; wb_data = 32'h0000CAFE;
    IR = 32'hFC000000; nPC = 32'h208;                 // unknown opcode
    push(cyc + 1, K_CTRL, C_SW, "sw_ctrl");
    push(cyc + 1, K_IMM, 32'h8, "sw_imm");
    push(cyc + 1, K_RD1, 32'h10, "sw_rd1");
    push(cyc + 1, K_RD2, 32'h0000CAFE, "bypass_rd2");
    step();
    wb_we = 1'b0; IR = 32'h00602020; nPC = 32'h20C;
    push(cyc + 1, K_CTRL, C_NONE, "unknown_op_ctrl");
    step();
    push(cyc + 1, K_RD1, 32'hDEADBEEF, "r3_persist");
    step();
    step();

    // async reset between edges with a would-be hazard present
    ex_mem_read = 1'b1; ex_rt = 5'd3; rst = 1'b1;
    push(cyc, K_CTRL, C_NONE, "midrst_ctrl");
    push(cyc, K_RD1, 32'h0, "midrst_rd1");
    push(cyc, K_NPC, 32'h0, "midrst_npc");
    push(cyc, K_IMM, 32'h0, "midrst_imm");
    push(cyc, K_IFID, 32'h0, "midrst_ifid");
    push(cyc, K_STALL, 32'h0, "midrst_stall");
    step();
    rst = 1'b0; ex_mem_read = 1'b0;
    step();
    push(cyc + 1, K_CTRL, C_R, "post_rst_ctrl");
    push(cyc + 1, K_RD1, 32'h0, "post_rst_r3_cleared");
    step(); step(); step(); step();

    foreach (sb[i]) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s never checked: due cycle %0d, expected 0x%08h", sb[i].name, sb[i].cyc, sb[i].val);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
